// File: rtl/mpq_host_if.sv
// mpq_host_if: loader (ld_*, start), readback (rd_*), run status and engine (data/cmd/busy/RAM_*/done) signals of mpq_host
interface mpq_host_if;
  logic       ld_valid;
  logic       ld_sel;
  logic [7:0] ld_data;
  logic [2:0] ld_cmd;
  logic [7:0] ld_index;
  logic [7:0] ld_value;
  logic       ld_ready;
  logic       start;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       run_done;
  logic [4:0] result_count;
  logic       err_overflow;
  logic       err_addr;
  logic       err_timeout;
  logic       mpq_rst;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       busy;
  logic       RAM_valid;
  logic [7:0] RAM_A;
  logic [7:0] RAM_D;
  logic       done;
  modport slave (
    input  ld_valid, ld_sel, ld_data, ld_cmd, ld_index, ld_value, start, rd_addr,
           busy, RAM_valid, RAM_A, RAM_D, done,
    output ld_ready, rd_data, run_done, result_count, err_overflow, err_addr, err_timeout,
           mpq_rst, data_valid, data, cmd_valid, cmd, index, value
  );
  modport master (
    output ld_valid, ld_sel, ld_data, ld_cmd, ld_index, ld_value, start, rd_addr,
           busy, RAM_valid, RAM_A, RAM_D, done,
    input  ld_ready, rd_data, run_done, result_count, err_overflow, err_addr, err_timeout,
           mpq_rst, data_valid, data, cmd_valid, cmd, index, value
  );
endinterface

// File: rtl/mpq_host.sv
// mpq_host: buffers a data set and command FIFO, resets/feeds/commands the priority-queue engine and captures its write-back; ports clk, rst, bus (mpq_host_if.slave)
module mpq_host #(
  parameter int DATA_LEN  = 12,
  parameter int CMD_DEPTH = 8,
  parameter int RAM_DEPTH = 16
) (
  input logic       clk,
  input logic       rst,
  mpq_host_if.slave bus
);
  localparam int DW = $clog2(DATA_LEN + 1);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int MW = $clog2(RAM_DEPTH);
  typedef enum logic [2:0] {IDLE, RST_ENG, SEND, WAIT_CMD, ISSUE, GAP, COLLECT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] dbuf_q [DATA_LEN];
  logic [18:0] fifo_q [CMD_DEPTH];
  logic [7:0] mem_q [RAM_DEPTH];
  logic [DW-1:0] dcnt_q, idx_q, idx_d;
  logic [AW:0] wp_q, rp_q;
  logic [7:0] wd_q, data_q, index_q, value_q, rd_data_q;
  logic [4:0] cnt_q;
  logic [2:0] cmd_q;
  logic [18:0] head;
  logic ld_ready_q, mpq_rst_q, dv_q, cv_q, run_done_q, ovf_q, addr_q, tmo_q;
  logic empty, full, dfull, go, ld_d, ld_c, wr, ram_ok, wd_max, tmo;
  assign empty = wp_q == rp_q;
  assign full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign head = fifo_q[rp_q[AW-1:0]];
  assign dfull = dcnt_q == DW'(DATA_LEN);
  assign go = state_q == IDLE && bus.start && dfull;
  assign ld_d = state_q == IDLE && bus.ld_valid && !bus.ld_sel;
  assign ld_c = state_q == IDLE && bus.ld_valid && bus.ld_sel;
  assign wr = state_q == COLLECT && bus.RAM_valid;
  assign ram_ok = bus.RAM_A < 8'(RAM_DEPTH);
  assign wd_max = &wd_q;
  assign tmo = wd_max && (state_q == WAIT_CMD ? bus.busy : state_q == COLLECT && !bus.done);
  assign idx_d = state_q == SEND ? idx_q + 1'b1 : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = go ? RST_ENG : IDLE;
      RST_ENG:  state_d = SEND;
      SEND:     state_d = idx_q == DW'(DATA_LEN - 1) ? WAIT_CMD : SEND;
      WAIT_CMD: state_d = !bus.busy ? (empty ? DONE : ISSUE) : (wd_max ? DONE : WAIT_CMD);
      ISSUE:    state_d = cmd_q == 3'd4 ? COLLECT : GAP;
      GAP:      state_d = WAIT_CMD;
      COLLECT:  state_d = bus.done || wd_max ? DONE : COLLECT;
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      idx_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      addr_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ld_ready_q <= 1'b1;
      mpq_rst_q  <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      cv_q       <= 1'b0;
      cmd_q      <= 3'b111;
      index_q    <= '0;
      value_q    <= '0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= state_q == DONE ? '0 : dcnt_q + DW'(ld_d && !dfull);
      idx_q      <= idx_d;
      wp_q       <= state_q == DONE ? '0 : wp_q + (AW+1)'(ld_c && !full);
      rp_q       <= state_q == DONE ? '0 : rp_q + (AW+1)'(state_q == ISSUE);
      wd_q       <= state_d == state_q && (state_q == WAIT_CMD || state_q == COLLECT) ? wd_q + 8'd1 : '0;
      cnt_q      <= go ? '0 : cnt_q + 5'(wr && ram_ok && !(&cnt_q));
      ovf_q      <= !go && (ovf_q || (ld_d && dfull) || (ld_c && full));
      addr_q     <= !go && (addr_q || (wr && !ram_ok));
      tmo_q      <= !go && (tmo_q || tmo);
      ld_ready_q <= state_d == IDLE;
      mpq_rst_q  <= state_d == RST_ENG;
      dv_q       <= state_d == SEND;
      data_q     <= state_d == SEND ? dbuf_q[idx_d] : '0;
      cv_q       <= state_d == ISSUE;
      cmd_q      <= state_d == ISSUE ? head[18:16] : 3'b111;
      index_q    <= state_d == ISSUE ? head[15:8] : '0;
      value_q    <= state_d == ISSUE ? head[7:0] : '0;
      run_done_q <= state_d == DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_d && !dfull) dbuf_q[dcnt_q] <= bus.ld_data;
    if (ld_c && !full) fifo_q[wp_q[AW-1:0]] <= {bus.ld_cmd, bus.ld_index, bus.ld_value};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr && ram_ok) mem_q[bus.RAM_A[MW-1:0]] <= bus.RAM_D;
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end
  assign bus.ld_ready     = ld_ready_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.run_done     = run_done_q;
  assign bus.result_count = cnt_q;
  assign bus.err_overflow = ovf_q;
  assign bus.err_addr     = addr_q;
  assign bus.err_timeout  = tmo_q;
  assign bus.mpq_rst      = mpq_rst_q;
  assign bus.data_valid   = dv_q;
  assign bus.data         = data_q;
  assign bus.cmd_valid    = cv_q;
  assign bus.cmd          = cmd_q;
  assign bus.index        = index_q;
  assign bus.value        = value_q;
endmodule

// File: tb/tb_mpq_host.sv
// tb_mpq_host: scoreboard bench for mpq_host with a hand-driven engine model
module tb_mpq_host;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_dv = 1'b0;
  logic [7:0] exp_data[$];
  logic [7:0] exp_rd[$];
  logic [18:0] exp_cmd[$];
  logic [7:0] exp_done[$];
  logic [7:0] t2 [12] = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5, 8'd3, 8'd5, 8'd8};
  logic [2:0] t4c [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
  localparam logic [47:0] RST_OUT = {1'b1, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0, 3'b111, 8'd0, 8'd0, 8'd0};
  mpq_host_if bus ();
  mpq_host dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_vld <= rd_req;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask
  task automatic miss(input string name, input logic [63:0] act);
    total++;
    $display("FAIL %s: got %0h, want no such event", name, act);
  endtask
  function automatic logic [47:0] outs();
    return {bus.ld_ready, bus.run_done, bus.result_count, bus.err_overflow, bus.err_addr, bus.err_timeout,
            bus.mpq_rst, bus.data_valid, bus.data, bus.cmd_valid, bus.cmd, bus.index, bus.value, bus.rd_data};
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      prev_rst <= 1'b0;
      prev_dv <= 1'b0;
    end else begin
      if (bus.mpq_rst) chk("mpq_rst_width", prev_rst, 0);
      if (bus.data_valid) begin
        if (!prev_dv) chk("first_byte_after_mpq_rst", prev_rst, 1);
        if (exp_data.size() == 0) miss("data_unexpected", bus.data);
        else chk("data", bus.data, exp_data.pop_front());
      end
      if (bus.cmd_valid) begin
        if (exp_cmd.size() == 0) miss("cmd_unexpected", {bus.cmd, bus.index, bus.value});
        else chk("cmd_issue", {bus.cmd, bus.index, bus.value}, exp_cmd.pop_front());
      end else chk("cmd_idle_code", {bus.cmd, bus.index, bus.value}, 19'h70000);
      if (bus.run_done) begin
        if (exp_done.size() == 0) miss("run_done_unexpected", bus.result_count);
        else chk("run_done_status", {bus.result_count, bus.err_overflow, bus.err_addr, bus.err_timeout}, exp_done.pop_front());
      end
      if (rd_vld) begin
        if (exp_rd.size() == 0) miss("rd_unexpected", bus.rd_data);
        else chk("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      prev_rst <= bus.mpq_rst;
      prev_dv <= bus.data_valid;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load_byte(input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_sel = 1'b0;
    bus.ld_data = b;
    tick();
    bus.ld_valid = 1'b0;
  endtask
  task automatic load_run(input int base, input int n, input int keep);
    for (int i = 0; i < n; i++) load_byte(8'(base + i));
    for (int i = 0; i < keep; i++) exp_data.push_back(8'(base + i));
  endtask
  task automatic load_cmd(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v, input bit expect_issue);
    bus.ld_valid = 1'b1;
    bus.ld_sel = 1'b1;
    bus.ld_cmd = c;
    bus.ld_index = i;
    bus.ld_value = v;
    tick();
    bus.ld_valid = 1'b0;
    if (expect_issue) exp_cmd.push_back({c, i, v});
  endtask
  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_issue(input logic [2:0] c, output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd == c) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      $display("FAIL issue_wait: got no issue of cmd %0d, want one within 400 cycles", c);
    end
  endtask
  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.run_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++;
      $display("FAIL run_done_wait: got no run_done, want one within 600 cycles");
    end
    tick();
  endtask
  task automatic readback(input logic [3:0] a, input logic [7:0] e);
    bus.rd_addr = a;
    rd_req = 1'b1;
    exp_rd.push_back(e);
    tick();
    rd_req = 1'b0;
    tick();
  endtask
  initial begin
    int at, at2, rel, dc;
    bit hit;
    bus.ld_valid = 1'b0;
    bus.ld_sel = 1'b0;
    bus.ld_data = '0;
    bus.ld_cmd = '0;
    bus.ld_index = '0;
    bus.ld_value = '0;
    bus.start = 1'b0;
    bus.rd_addr = '0;
    bus.busy = 1'b0;
    bus.RAM_valid = 1'b0;
    bus.RAM_A = '0;
    bus.RAM_D = '0;
    bus.done = 1'b0;
    tick(3);
    chk("reset_outputs", outs(), RST_OUT);
    rst = 1'b0;
    tick();
    load_run(10, 12, 12);
    exp_done.push_back(8'h00);
    start_run();
    wait_done(at);
    chk("ld_ready_after_run", bus.ld_ready, 1);
    foreach (t2[i]) begin
      load_byte(t2[i]);
      exp_data.push_back(t2[i]);
    end
    load_cmd(3'd0, 8'd0, 8'd0, 1'b1);
    load_cmd(3'd4, 8'd0, 8'd0, 1'b1);
    exp_done.push_back({5'd1, 3'b000});
    start_run();
    wait_issue(3'd4, at);
    tick();
    bus.RAM_valid = 1'b1;
    bus.RAM_A = 8'd0;
    bus.RAM_D = 8'd9;
    tick();
    bus.RAM_valid = 1'b0;
    bus.done = 1'b1;
    dc = cyc;
    tick();
    bus.done = 1'b0;
    wait_done(at);
    chk("run_done_after_done", at, dc + 1);
    readback(4'd0, 8'd9);
    load_run(20, 12, 12);
    load_cmd(3'd1, 8'd5, 8'd7, 1'b1);
    load_cmd(3'd2, 8'd0, 8'd0, 1'b1);
    exp_done.push_back(8'h00);
    start_run();
    wait_issue(3'd1, at);
    tick();
    bus.busy = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_sel = 1'b1;
    bus.ld_cmd = 3'd3;
    bus.ld_index = 8'd1;
    bus.ld_value = 8'd1;
    tick();
    bus.ld_valid = 1'b0;
    tick(19);
    bus.busy = 1'b0;
    rel = cyc;
    wait_issue(3'd2, at2);
    chk("busy_release_issue", at2, rel + 1);
    wait_done(at);
    load_run(50, 12, 12);
    for (int i = 0; i < 8; i++) load_cmd(t4c[i], 8'(i), 8'(10 * i), 1'b1);
    chk("no_overflow_at_full", bus.err_overflow, 0);
    load_cmd(t4c[8], 8'd9, 8'd9, 1'b0);
    chk("cmd_overflow_flag", bus.err_overflow, 1);
    exp_done.push_back(8'h00);
    start_run();
    wait_done(at);
    load_run(30, 13, 12);
    chk("data_overflow_flag", bus.err_overflow, 1);
    load_cmd(3'd1, 8'd3, 8'd3, 1'b1);
    load_cmd(3'd2, 8'd0, 8'd0, 1'b0);
    exp_done.push_back({5'd0, 3'b001});
    start_run();
    wait_issue(3'd1, at);
    tick();
    bus.busy = 1'b1;
    wait_done(at2);
    chk("timeout_latency", at2, at + 258);
    bus.busy = 1'b0;
    load_run(70, 12, 12);
    load_cmd(3'd4, 8'd0, 8'd0, 1'b1);
    exp_done.push_back({5'd1, 3'b010});
    start_run();
    wait_issue(3'd4, at);
    tick();
    bus.RAM_valid = 1'b1;
    bus.RAM_A = 8'd20;
    bus.RAM_D = 8'd77;
    tick();
    bus.RAM_A = 8'd1;
    bus.RAM_D = 8'd33;
    tick();
    bus.RAM_valid = 1'b0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_done(at);
    readback(4'd4, 8'd0);
    readback(4'd1, 8'd33);
    readback(4'd0, 8'd9);
    load_run(100, 12, 6);
    start_run();
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      hit = bus.data_valid && bus.data == 8'd105;
    end
    if (!hit) begin
      total++;
      $display("FAIL byte5_wait: got no byte 105, want it within 40 cycles");
    end
    #1 rst = 1'b1;
    #1 chk("reset_outputs_async", outs(), RST_OUT);
    tick(2);
    rst = 1'b0;
    tick();
    chk("ld_ready_after_reset", bus.ld_ready, 1);
    start_run();
    tick(4);
    chk("start_ignored_short_data", bus.ld_ready, 1);
    readback(4'd0, 8'd0);
    chk("data_queue_left", exp_data.size(), 0);
    chk("cmd_queue_left", exp_cmd.size(), 0);
    chk("done_queue_left", exp_done.size(), 0);
    chk("rd_queue_left", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
